// File: rtl/bus_pkg.sv
// Shared types and defaults for the bus master slice.
// State encoding plus width and latency defaults.
package bus_pkg;

  localparam int ADDR_W_DEF       = 8;
  localparam int DATA_W_DEF       = 8;
  localparam int READ_LATENCY_DEF = 2;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ_WAIT,
    READ_CAP,
    FINISH
  } state_t;

endpackage

// File: rtl/bus_tri_drv.sv
// Tristate driver for the shared data bus.
// The only place in the design that drives a high-impedance value.
module bus_tri_drv #(
  parameter int DATA_W = 8
) (
  input  logic              en,
  input  logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] din,
  inout  wire  [DATA_W-1:0] pad
);

  assign pad = en ? dout : {DATA_W{1'bz}};
  assign din = pad;

endmodule

// File: rtl/bus_master.sv
// Single-client master for a shared tristate bus with fixed read latency.
// Define BUS_MASTER_BURST_EN to build in multi-beat bursts driven by REQ_LEN.
module bus_master
  import bus_pkg::*;
#(
  parameter int READ_LATENCY = READ_LATENCY_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ,
  input  logic              REQ_WE,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_WDATA,
  input  logic [3:0]        REQ_LEN,
  output logic              BUSY,
  output logic              DONE,
  output logic [DATA_W-1:0] RDATA,
  output logic              RDATA_VALID,
  output logic [ADDR_W-1:0] BUS_ADDR,
  output logic              BUS_WE,
  inout  wire  [DATA_W-1:0] BUS_DATA
);

  localparam logic [2:0] WAIT_LAST =
    (READ_LATENCY > 1) ? 3'(READ_LATENCY - 2) : 3'd0;
  localparam state_t RD_FIRST =
    (READ_LATENCY > 1) ? READ_WAIT : READ_CAP;

  state_t            state_q;
  state_t            state_d;
  logic [2:0]        wait_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] bus_din;
  logic              drive;
  logic              last_beat;
  logic              accept;
  logic              step;

`ifdef BUS_MASTER_BURST_EN
  logic [3:0] len_q;
  assign last_beat = (len_q == 4'd0);
`else
  logic unused_len;
  assign unused_len = ^REQ_LEN;
  assign last_beat  = 1'b1;
`endif

  assign accept = (state_q == IDLE) && REQ;
  assign step   = !last_beat &&
                  (state_q == WRITE || state_q == READ_CAP);

  always_ff @(posedge CLK) begin
    if (!RESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    BUSY    = 1'b0;
    DONE    = 1'b0;
    BUS_WE  = 1'b0;
    drive   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (REQ) state_d = REQ_WE ? WRITE : RD_FIRST;
      end
      WRITE: begin
        BUSY   = 1'b1;
        BUS_WE = 1'b1;
        drive  = 1'b1;
        if (last_beat) state_d = FINISH;
      end
      READ_WAIT: begin
        BUSY = 1'b1;
        if (wait_q == WAIT_LAST) state_d = READ_CAP;
      end
      READ_CAP: begin
        BUSY    = 1'b1;
        state_d = last_beat ? FINISH : RD_FIRST;
      end
      FINISH: begin
        DONE    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus address stays put between transactions; it only moves on accept or beat step.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      BUS_ADDR    <= '0;
      wdata_q     <= '0;
      RDATA       <= '0;
      RDATA_VALID <= 1'b0;
      wait_q      <= '0;
`ifdef BUS_MASTER_BURST_EN
      len_q       <= '0;
`endif
    end else begin
      RDATA_VALID <= 1'b0;
      if (state_q == READ_WAIT) wait_q <= wait_q + 3'd1;
      else                      wait_q <= '0;
      if (accept) begin
        BUS_ADDR <= REQ_ADDR;
        wdata_q  <= REQ_WDATA;
`ifdef BUS_MASTER_BURST_EN
        len_q    <= REQ_LEN;
`endif
      end
      if (state_q == READ_CAP) begin
        RDATA       <= bus_din;
        RDATA_VALID <= 1'b1;
      end
      if (step) begin
        BUS_ADDR <= BUS_ADDR + 1'b1;
`ifdef BUS_MASTER_BURST_EN
        len_q    <= len_q - 4'd1;
`endif
        if (state_q == WRITE) wdata_q <= REQ_WDATA;
      end
    end
  end

  bus_tri_drv #(
    .DATA_W (DATA_W)
  ) u_tri (
    .en   (drive),
    .dout (wdata_q),
    .din  (bus_din),
    .pad  (BUS_DATA)
  );

endmodule

// File: tb/tb_bus_master.sv
// Directed bench for bus_master with an asynchronous-read bus RAM model.
// RAM drives the bus whenever BUS_WE is low; reset preloads mem[i] = i ^ 0x5A.
module tb_bus_master;

  logic       clk;
  logic       rst_n;
  logic       req;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic [3:0] req_len;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       rdata_valid;
  logic [7:0] bus_addr;
  logic       bus_we;
  wire  [7:0] bus_data;

  logic [7:0] mem [256];

  int n_cmp = 0;
  int n_bad = 0;

  bus_master #(
    .READ_LATENCY (2),
    .ADDR_W       (8),
    .DATA_W       (8)
  ) dut (
    .CLK         (clk),
    .RESET       (rst_n),
    .REQ         (req),
    .REQ_WE      (req_we),
    .REQ_ADDR    (req_addr),
    .REQ_WDATA   (req_wdata),
    .REQ_LEN     (req_len),
    .BUSY        (busy),
    .DONE        (done),
    .RDATA       (rdata),
    .RDATA_VALID (rdata_valid),
    .BUS_ADDR    (bus_addr),
    .BUS_WE      (bus_we),
    .BUS_DATA    (bus_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus_data = bus_we ? 8'bz : mem[bus_addr];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
    end else if (bus_we) begin
      mem[bus_addr] <= bus_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_cmp++;
    if ({busy, done, rdata_valid, bus_we} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_ctl: got %b want 0000",
               {busy, done, rdata_valid, bus_we});
    end
    n_cmp++;
    if (rdata !== 8'h00 || bus_addr !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_regs: rdata=%h addr=%h want 00 00", rdata, bus_addr);
    end
    n_cmp++;
    if (bus_data !== 8'h5A) begin
      n_bad++;
      $display("FAIL reset_bus: got %h want 5a", bus_data);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write();
    req = 1'b1; req_we = 1'b1; req_addr = 8'h10; req_wdata = 8'hA5;
    step();
    req = 1'b0;
    n_cmp++;
    if (bus_we !== 1'b1 || bus_addr !== 8'h10 || bus_data !== 8'hA5) begin
      n_bad++;
      $display("FAIL write_beat: we=%b addr=%h data=%h want 1 10 a5",
               bus_we, bus_addr, bus_data);
    end
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL write_busy: busy=%b done=%b want 1 0", busy, done);
    end
    step();
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || bus_we !== 1'b0) begin
      n_bad++;
      $display("FAIL write_finish: done=%b busy=%b we=%b want 1 0 0",
               done, busy, bus_we);
    end
    step();
    n_cmp++;
    if (done !== 1'b0 || bus_addr !== 8'h10 || bus_data !== 8'hA5) begin
      n_bad++;
      $display("FAIL write_idle: done=%b addr=%h mem=%h want 0 10 a5",
               done, bus_addr, bus_data);
    end
  endtask

  task automatic test_read();
    logic [7:0] ra [2];
    logic [7:0] re [2];
    int first, nv, nd, bad;
    ra[0] = 8'h11; re[0] = 8'h4B;
    ra[1] = 8'h10; re[1] = 8'hA5;
    for (int t = 0; t < 2; t++) begin
      req = 1'b1; req_we = 1'b0; req_addr = ra[t];
      step();
      req = 1'b0;
      first = 0; nv = 0; nd = 0; bad = 0;
      for (int k = 1; k <= 6; k++) begin
        if (rdata_valid) begin
          nv++;
          if (first == 0) first = k;
        end
        if (done) nd++;
        if (bus_we || bus_data !== re[t]) bad++;
        step();
      end
      n_cmp++;
      if (first != 3 || nv != 1) begin
        n_bad++;
        $display("FAIL read_valid[%0d]: at=%0d pulses=%0d want 3 1", t, first, nv);
      end
      n_cmp++;
      if (rdata !== re[t]) begin
        n_bad++;
        $display("FAIL read_data[%0d]: got %h want %h", t, rdata, re[t]);
      end
      n_cmp++;
      if (bad != 0 || nd != 1) begin
        n_bad++;
        $display("FAIL read_bus[%0d]: bad=%0d done=%0d want 0 1", t, bad, nd);
      end
    end
  endtask

  task automatic test_busy();
    int nd, nw;
    req = 1'b1; req_we = 1'b1; req_addr = 8'h20; req_wdata = 8'h3C;
    step();
    req_addr = 8'h30; req_wdata = 8'hFF;
    nd = 0; nw = 0;
    for (int k = 0; k < 6; k++) begin
      if (done) nd++;
      if (bus_we) nw++;
      if (k == 2) req = 1'b0;
      step();
    end
    n_cmp++;
    if (nd != 1 || nw != 1) begin
      n_bad++;
      $display("FAIL busy_count: done=%0d writes=%0d want 1 1", nd, nw);
    end
    n_cmp++;
    if (bus_addr !== 8'h20 || bus_data !== 8'h3C || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_bus: addr=%h mem=%h busy=%b want 20 3c 0",
               bus_addr, bus_data, busy);
    end
  endtask

  task automatic test_reset_mid_read();
    int nd, nv;
    req = 1'b1; req_we = 1'b0; req_addr = 8'h10;
    step();
    req = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_pre: busy=%b want 1", busy);
    end
    rst_n = 1'b0;
    step();
    n_cmp++;
    if ({busy, done, rdata_valid, bus_we} !== 4'b0000) begin
      n_bad++;
      $display("FAIL midrst_ctl: got %b want 0000",
               {busy, done, rdata_valid, bus_we});
    end
    n_cmp++;
    if (rdata !== 8'h00 || bus_addr !== 8'h00 || bus_data !== 8'h5A) begin
      n_bad++;
      $display("FAIL midrst_regs: rdata=%h addr=%h bus=%h want 00 00 5a",
               rdata, bus_addr, bus_data);
    end
    rst_n = 1'b1;
    nd = 0; nv = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (done) nd++;
      if (rdata_valid) nv++;
    end
    n_cmp++;
    if (nd != 0 || nv != 0) begin
      n_bad++;
      $display("FAIL midrst_after: done=%0d valid=%0d want 0 0", nd, nv);
    end
  endtask

`ifdef BUS_MASTER_BURST_EN
  task automatic test_burst();
    logic [7:0] ea [4];
    logic [7:0] ev [4];
    int nw, nd, nv;
    ea[0] = 8'hFE; ea[1] = 8'hFF; ea[2] = 8'h00; ea[3] = 8'h01;
    ev[0] = 8'h01; ev[1] = 8'h02; ev[2] = 8'h03; ev[3] = 8'h04;
    req = 1'b1; req_we = 1'b1; req_addr = 8'hFE; req_wdata = 8'h01;
    req_len = 4'd3;
    step();
    req = 1'b0;
    nw = 0; nd = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus_we) begin
        if (nw < 4) begin
          n_cmp++;
          if (bus_addr !== ea[nw] || bus_data !== ev[nw]) begin
            n_bad++;
            $display("FAIL burst_wr[%0d]: addr=%h data=%h want %h %h",
                     nw, bus_addr, bus_data, ea[nw], ev[nw]);
          end
        end
        nw++;
      end
      if (done) nd++;
      req_wdata = 8'(k + 2);
      step();
    end
    n_cmp++;
    if (nw != 4 || nd != 1) begin
      n_bad++;
      $display("FAIL burst_wr_cnt: beats=%0d done=%0d want 4 1", nw, nd);
    end
    req = 1'b1; req_we = 1'b0; req_addr = 8'hFE; req_len = 4'd3;
    step();
    req = 1'b0;
    nv = 0; nd = 0;
    for (int k = 0; k < 16; k++) begin
      if (rdata_valid) begin
        if (nv < 4) begin
          n_cmp++;
          if (rdata !== ev[nv]) begin
            n_bad++;
            $display("FAIL burst_rd[%0d]: got %h want %h", nv, rdata, ev[nv]);
          end
        end
        nv++;
      end
      if (done) nd++;
      step();
    end
    n_cmp++;
    if (nv != 4 || nd != 1) begin
      n_bad++;
      $display("FAIL burst_rd_cnt: pulses=%0d done=%0d want 4 1", nv, nd);
    end
    req_len = 4'd0;
  endtask
`else
  task automatic test_no_burst();
    int nw, nd, fd;
    req = 1'b1; req_we = 1'b1; req_addr = 8'h40; req_wdata = 8'h99;
    req_len = 4'd3;
    step();
    req = 1'b0;
    nw = 0; nd = 0; fd = -1;
    for (int k = 0; k < 6; k++) begin
      if (bus_we) nw++;
      if (done) begin
        nd++;
        if (fd < 0) fd = k;
      end
      step();
    end
    n_cmp++;
    if (nw != 1 || nd != 1 || fd != 1) begin
      n_bad++;
      $display("FAIL noburst_cnt: writes=%0d done=%0d at=%0d want 1 1 1",
               nw, nd, fd);
    end
    n_cmp++;
    if (bus_addr !== 8'h40 || bus_data !== 8'h99) begin
      n_bad++;
      $display("FAIL noburst_bus: addr=%h mem=%h want 40 99", bus_addr, bus_data);
    end
    req_len = 4'd0;
  endtask
`endif

  initial begin
    rst_n = 1'b0; req = 1'b0; req_we = 1'b0;
    req_addr = 8'h00; req_wdata = 8'h00; req_len = 4'd0;
    test_reset();
    test_write();
    test_read();
    test_busy();
    test_reset_mid_read();
`ifdef BUS_MASTER_BURST_EN
    test_burst();
`else
    test_no_burst();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_master.md
BUS_MASTER -- requirements
Module: bus_master

Interface
REQ-001 Parameter: READ_LATENCY, 2, clock edges from BUS_ADDR presentation to the cycle BUS_DATA is sampled; legal range 1-7.
REQ-002 Parameter: ADDR_W, 8, bus address width.
REQ-003 Parameter: DATA_W, 8, bus data width.
REQ-004 Port CLK input 1: single clock; all logic on rising edge.
REQ-005 Port RESET input 1: synchronous, active-low reset.
REQ-006 Port REQ input 1: client transaction request.
REQ-007 Port REQ_WE input 1: 1 = write, 0 = read; sampled with REQ.
REQ-008 Port REQ_ADDR input ADDR_W: start address; sampled with REQ.
REQ-009 Port REQ_WDATA input DATA_W: write data; sampled with REQ and at each burst-write beat.
REQ-010 Port REQ_LEN input 4: burst beats minus one; ignored unless burst is compiled in.
REQ-011 Port BUSY output 1: transaction in progress.
REQ-012 Port DONE output 1: one-cycle pulse at the end of a transaction.
REQ-013 Port RDATA output DATA_W: last read data.
REQ-014 Port RDATA_VALID output 1: one-cycle pulse per captured read beat.
REQ-015 Port BUS_ADDR output ADDR_W: shared-bus address.
REQ-016 Port BUS_WE output 1: shared-bus write enable.
REQ-017 Port BUS_DATA inout DATA_W: shared tristate data bus.

Function
REQ-018 The FSM states are IDLE, WRITE, READ_WAIT, READ_CAP and FINISH.
REQ-019 In IDLE, REQ=1 at an edge latches REQ_WE, REQ_ADDR, REQ_WDATA and REQ_LEN, sets BUSY=1, and moves to WRITE if REQ_WE=1 or to READ_WAIT otherwise.
REQ-020 REQ is ignored while BUSY=1; no queueing takes place.
REQ-021 In WRITE, for exactly one cycle per beat, BUS_WE=1, BUS_ADDR=latched address, and BUS_DATA is driven with the write data.
REQ-022 BUS_DATA is high-impedance in every state other than WRITE.
REQ-023 In READ_WAIT, BUS_WE=0 and BUS_ADDR is held for READ_LATENCY-1 cycles, then the FSM enters READ_CAP.
REQ-024 In READ_CAP, BUS_DATA is registered into RDATA and RDATA_VALID=1 in the following cycle.
REQ-025 Single-read latency is READ_LATENCY+1 cycles from REQ acceptance to RDATA_VALID.
REQ-026 After the last beat, the FSM enters FINISH: DONE=1 for one cycle, BUSY=0 in the same cycle, then IDLE.
REQ-027 A new REQ is accepted no earlier than the cycle after FINISH.
REQ-028 RDATA holds its value until the next capture.
REQ-029 BUS_ADDR holds its last value while idle.

Reset
REQ-030 RESET=0 at an edge forces IDLE, BUSY=0, DONE=0, RDATA=0, RDATA_VALID=0, BUS_WE=0, BUS_ADDR=0, and BUS_DATA to high-impedance.
REQ-031 A reset taken mid-transaction aborts the transaction with no DONE pulse; a partial burst is not resumed.

Configuration
REQ-032 Burst support is compiled in by the macro BUS_MASTER_BURST_EN.
REQ-033 With BUS_MASTER_BURST_EN defined: a transaction is REQ_LEN+1 beats, BUS_ADDR increments by 1 per beat with wrap 0xFF->0x00, and write beats take back-to-back cycles with REQ_WDATA resampled per beat.
REQ-034 With BUS_MASTER_BURST_EN defined: read beats each repeat the READ_WAIT/READ_CAP sequence, and DONE pulses once after the final beat.
REQ-035 Without BUS_MASTER_BURST_EN: REQ_LEN is ignored, every transaction is one beat, and the port still exists.

Structure
REQ-036 Package bus_pkg holds the FSM state enum, the ADDR_W/DATA_W defaults and the READ_LATENCY default.
REQ-037 Sub-module bus_tri_drv holds the DATA_W tristate driver (enable, out-data, in-data).
REQ-038 No other tristate logic exists outside bus_tri_drv.

Verification
REQ-039 Write: REQ=1, REQ_WE=1, REQ_ADDR=0x10, REQ_WDATA=0xA5 -> next cycle BUS_WE=1, BUS_ADDR=0x10, BUS_DATA=0xA5 for one cycle, then DONE pulses once.
REQ-040 Read back with a bus_ram model: REQ_WE=0, REQ_ADDR=0x10 -> RDATA=0xA5 with RDATA_VALID exactly 3 cycles after acceptance; BUS_DATA never driven by the master.
REQ-041 Busy: second REQ asserted while BUSY=1 -> ignored, with exactly one DONE and the bus unaffected.
REQ-042 Reset mid-read: RESET=0 in READ_WAIT -> all outputs at reset values next edge, no DONE, and BUS_DATA high-impedance.
REQ-043 Burst (BUS_MASTER_BURST_EN): write REQ_LEN=3 at 0xFE with data 1,2,3,4 -> BUS_ADDR sequence FE,FF,00,01; burst read of the same range returns 1,2,3,4 with 4 RDATA_VALID pulses.
REQ-044 No burst (macro undefined): REQ_LEN=3 -> single beat only, and DONE follows 1 write cycle.
